ex_alu_forward: RTL and testbench

Execute-stage datapath core for the 5-stage pipeline. It resolves RAW hazards by forwarding results from the MEM and WB stages onto the two register operands. It computes the ALU result, the address sum and the zero flag combinationally, then registers the result, sum and zero flag into an EX/MEM-side output register.

---
 rtl/ex_alu_forward.sv | 121 ++++++++++++
 tb/tb_ex_alu_forward.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_forward.sv
// Execute-stage datapath: MEM/WB operand forwarding, ALU, address adder and zero flag,
// with an EX/MEM-side output register for result, sum and zero.
module ex_alu_forward (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [37:0] mem_back,
    input  logic [37:0] wb_back,
    input  logic        use_mem_back,
    input  logic        use_wb_back,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] ext_b,
    input  logic        alu_src,
    input  logic [3:0]  aluop,
    input  logic [4:0]  sa,
    output logic [31:0] f_rd1,
    output logic [31:0] f_rd2,
    output logic [31:0] alu_c,
    output logic [31:0] sum,
    output logic        zero,
    output logic [31:0] alu_c_q,
    output logic [31:0] sum_q,
    output logic        zero_q
);
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    typedef struct packed {
        logic          reg_write;
        logic [RW-1:0] rw;
        logic [DW-1:0] data;
    } back_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR    = 4'd3,
        OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU  = 4'd7,
        OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_SLLV  = 4'd11,
        OP_SRLV = 4'd12, OP_SRAV = 4'd13, OP_LUI  = 4'd14, OP_PASSB = 4'd15
    } alu_op_t;

    back_t         mem_b;
    back_t         wb_b;
    logic          mem_hit_a;
    logic          wb_hit_a;
    logic          mem_hit_b;
    logic          wb_hit_b;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    alu_op_t       op;

    assign mem_b = mem_back;
    assign wb_b  = wb_back;
    assign op    = alu_op_t'(aluop);

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    assign mem_hit_a = use_mem_back && mem_b.reg_write && (mem_b.rw == rs) && (rs != '0);
    assign wb_hit_a  = use_wb_back  && wb_b.reg_write  && (wb_b.rw  == rs) && (rs != '0);
    assign mem_hit_b = use_mem_back && mem_b.reg_write && (mem_b.rw == rt) && (rt != '0);
    assign wb_hit_b  = use_wb_back  && wb_b.reg_write  && (wb_b.rw  == rt) && (rt != '0);

    // Operand forwarding; MEM is younger than WB so it wins.
    always_comb begin
        f_rd1 = rd1;
        f_rd2 = rd2;
        if (mem_hit_a) begin
            f_rd1 = mem_b.data;
        end else if (wb_hit_a) begin
            f_rd1 = wb_b.data;
        end
        if (mem_hit_b) begin
            f_rd2 = mem_b.data;
        end else if (wb_hit_b) begin
            f_rd2 = wb_b.data;
        end
    end

    assign op_a = f_rd1;
    assign op_b = alu_src ? ext_b : f_rd2;
    assign sum  = op_a + op_b;

    always_comb begin
        alu_c = op_b;
        case (op)
            OP_ADD:   alu_c = op_a + op_b;
            OP_SUB:   alu_c = op_a - op_b;
            OP_AND:   alu_c = op_a & op_b;
            OP_OR:    alu_c = op_a | op_b;
            OP_XOR:   alu_c = op_a ^ op_b;
            OP_NOR:   alu_c = ~(op_a | op_b);
            OP_SLT:   alu_c = DW'($signed(op_a) < $signed(op_b));
            OP_SLTU:  alu_c = DW'(op_a < op_b);
            OP_SLL:   alu_c = op_b << sa;
            OP_SRL:   alu_c = op_b >> sa;
            OP_SRA:   alu_c = DW'($signed(op_b) >>> sa);
            OP_SLLV:  alu_c = op_b << op_a[RW-1:0];
            OP_SRLV:  alu_c = op_b >> op_a[RW-1:0];
            OP_SRAV:  alu_c = DW'($signed(op_b) >>> op_a[RW-1:0]);
            OP_LUI:   alu_c = {op_b[15:0], 16'b0};
            OP_PASSB: alu_c = op_b;
        endcase
    end

    assign zero = (alu_c == '0);

    // EX/MEM output register; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_c_q <= '0;
            sum_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            alu_c_q <= alu_c;
            sum_q   <= sum;
            zero_q  <= zero;
        end
    end

endmodule

// File: tb/tb_ex_alu_forward.sv
// Randomized and directed bench for ex_alu_forward against an arithmetic reference model.
module tb_ex_alu_forward;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [37:0] mem_back, wb_back;
    logic        use_mem_back, use_wb_back;
    logic [4:0]  rs, rt, sa;
    logic [31:0] rd1, rd2, ext_b;
    logic        alu_src;
    logic [3:0]  aluop;
    logic [31:0] f_rd1, f_rd2, alu_c, sum, alu_c_q, sum_q;
    logic        zero, zero_q;

    int n_cmp = 0;
    int n_err = 0;

    ex_alu_forward dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_back(mem_back), .wb_back(wb_back),
        .use_mem_back(use_mem_back), .use_wb_back(use_wb_back),
        .rs(rs), .rt(rt), .rd1(rd1), .rd2(rd2), .ext_b(ext_b),
        .alu_src(alu_src), .aluop(aluop), .sa(sa),
        .f_rd1(f_rd1), .f_rd2(f_rd2), .alu_c(alu_c), .sum(sum), .zero(zero),
        .alu_c_q(alu_c_q), .sum_q(sum_q), .zero_q(zero_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Source lookup in priority order: younger MEM result, then WB result, then register file.
    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf);
        logic [37:0] srcs [2];
        logic        ens  [2];
        srcs[0] = mem_back; ens[0] = use_mem_back;
        srcs[1] = wb_back;  ens[1] = use_wb_back;
        if (r == 5'd0) return rf;
        foreach (srcs[i])
            if (ens[i] && srcs[i][37] && srcs[i][36:32] == r) return srcs[i][31:0];
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] s);
        longint unsigned ua = a, ub = b;
        longint          sa_v = $signed(a), sb_v = $signed(b);
        longint unsigned p2 = 64'd1 << s;
        longint unsigned p2v = 64'd1 << a[4:0];
        case (op)
            4'd0:  return 32'(ua + ub);
            4'd1:  return 32'(ua + 64'h1_0000_0000 - ub);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa_v < sb_v) ? 32'd1 : 32'd0;
            4'd7:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd8:  return 32'(ub * p2);
            4'd9:  return 32'(ub / p2);
            4'd10: return 32'(sb_v >>> s);
            4'd11: return 32'(ub * p2v);
            4'd12: return 32'(ub / p2v);
            4'd13: return 32'(sb_v >>> a[4:0]);
            4'd14: return 32'((ub % 64'd65536) * 64'd65536);
            default: return b;
        endcase
    endfunction

    // Check combinational outputs, clock once, then check the registered copy.
    task automatic cycle();
        logic [31:0] ea, eb, ec, es;
        logic        ez, clr;
        #1;
        ea  = ref_fwd(rs, rd1);
        eb  = alu_src ? ext_b : ref_fwd(rt, rd2);
        ec  = ref_alu(aluop, ea, eb, sa);
        es  = 32'(longint'(ea) + longint'(eb));
        ez  = (ec == 32'd0);
        clr = rst | flush;
        check("f_rd1", f_rd1, ea);
        check("f_rd2", f_rd2, ref_fwd(rt, rd2));
        check("alu_c", alu_c, ec);
        check("sum",   sum,   es);
        check("zero",  32'(zero), 32'(ez));
        @(posedge clk); #1;
        check("alu_c_q", alu_c_q, clr ? 32'd0 : ec);
        check("sum_q",   sum_q,   clr ? 32'd0 : es);
        check("zero_q",  32'(zero_q), clr ? 32'd0 : 32'(ez));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0;
        mem_back = '0; wb_back = '0; use_mem_back = 1'b0; use_wb_back = 1'b0;
        rs = 5'd1; rt = 5'd2; rd1 = '0; rd2 = '0; ext_b = '0;
        alu_src = 1'b0; aluop = 4'd0; sa = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu_c_q", alu_c_q, 32'd0);
        check("rst_sum_q",   sum_q,   32'd0);
        check("rst_zero_q",  32'(zero_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Forwarding priority
        rs = 5'd5; rd1 = 32'd1;
        mem_back = {1'b1, 5'd5, 32'hAAAA0000};
        wb_back  = {1'b1, 5'd5, 32'hBBBB0000};
        use_mem_back = 1'b1; use_wb_back = 1'b1;
        #1 check("fwd_mem_prio", f_rd1, 32'hAAAA0000);
        use_mem_back = 1'b0;
        #1 check("fwd_wb", f_rd1, 32'hBBBB0000);
        use_mem_back = 1'b1; mem_back[37] = 1'b0; wb_back[37] = 1'b0;
        #1 check("fwd_none", f_rd1, 32'd1);
        cycle();

        // Register 0 guard
        rt = 5'd0; rd2 = 32'd0; mem_back = {1'b1, 5'd0, 32'hFFFFFFFF}; wb_back = '0;
        #1 check("r0_guard", f_rd2, 32'd0);
        cycle();
        idle_inputs();

        // Arithmetic and compare
        rd1 = 32'h7FFFFFFF; rd2 = 32'd1; aluop = 4'd0;
        #1 check("add_ovf", alu_c, 32'h80000000);
        cycle();
        rd1 = 32'd5; rd2 = 32'd5; aluop = 4'd1;
        #1 check("sub_zero", 32'(zero), 32'd1);
        cycle();
        rd1 = 32'hFFFFFFFF; rd2 = 32'd1; aluop = 4'd6;
        #1 check("slt", alu_c, 32'd1);
        aluop = 4'd7;
        #1 check("sltu", alu_c, 32'd0);
        cycle();

        // Shifts and immediate ops
        rd2 = 32'h80000000; sa = 5'd4; aluop = 4'd10;
        #1 check("sra", alu_c, 32'hF8000000);
        aluop = 4'd9;
        #1 check("srl", alu_c, 32'h08000000);
        cycle();
        rd1 = 32'h21; rd2 = 32'd1; aluop = 4'd11;
        #1 check("sllv", alu_c, 32'd2);
        cycle();
        alu_src = 1'b1; ext_b = 32'h1234; aluop = 4'd14;
        #1 check("lui", alu_c, 32'h12340000);
        cycle();
        rd1 = 32'h1000; ext_b = 32'hFFFFFFFC;
        for (int op = 0; op < 16; op++) begin
            aluop = 4'(op);
            #1 check("sum_any_op", sum, 32'hFFC);
        end
        cycle();
        idle_inputs();

        // Registered path, flush and reset release
        rd1 = 32'd3; rd2 = 32'd4; aluop = 4'd0;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0; rst = 1'b1; rd1 = 32'd1; rd2 = 32'd1; aluop = 4'd1;
        cycle();
        rst = 1'b0;
        cycle();
        check("zero_q_after_rst", 32'(zero_q), 32'd1);

        // Randomized traffic with clustered register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            mem_back = {1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)};
            wb_back  = {1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)};
            use_mem_back = 1'($urandom);
            use_wb_back  = 1'($urandom);
            rd1 = ($urandom_range(0, 7) == 0) ? rd2 : 32'($urandom);
            rd2 = 32'($urandom);
            ext_b = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : 32'($urandom);
            alu_src = 1'($urandom);
            aluop = 4'($urandom);
            sa = 5'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
